// File: rtl/heater_pkg.sv
// Definitions shared by the heater PWM driver and the PID block that feeds it:
// response format defaults, driver state encoding and command saturation.
package heater_pkg;

    localparam int unsigned RESP_WIDTH = 12;
    localparam int unsigned RESP_FRAC  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } drv_state_t;

    // Integer part of a signed fixed-point command, clamped to [0, 2^pb-1].
    // The arithmetic shift truncates towards minus infinity, so every negative
    // input (including small negative fractions) lands at or below zero.
    function automatic logic [31:0] sat_duty(
        input logic signed [31:0] value,
        input int unsigned        frac,
        input int unsigned        pb
    );
        logic signed [31:0] ipart;
        logic signed [31:0] maxv;
        ipart = value >>> frac;
        maxv  = (32'sd1 <<< pb) - 32'sd1;
        if (ipart <= 32'sd0) begin
            sat_duty = 32'd0;
        end else if (ipart > maxv) begin
            sat_duty = maxv;
        end else begin
            sat_duty = ipart;
        end
    endfunction

endpackage

// File: rtl/pwm_counter.sv
// Free-running PWM period counter: period boundary detection, registered
// period_start pulse and the registered heater compare against the duty.
module pwm_counter #(
    parameter int unsigned PB = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [PB-1:0] duty_i,
    input  logic          en_i,
    output logic          boundary_o,
    output logic          period_start_o,
    output logic          heater_on_o
);

    localparam logic [PB-1:0] CNT_MAX = {PB{1'b1}};

    logic          armed_q;
    logic [PB-1:0] cnt_q;
    logic [PB-1:0] cnt_d;
    logic          period_start_q;
    logic          heater_on_q;

    // The first edge after reset opens period 0 without advancing the count.
    always_comb begin
        if (armed_q) begin
            cnt_d = cnt_q + {{(PB-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {PB{1'b0}};
        end
    end

    assign boundary_o = armed_q && (cnt_q == CNT_MAX);

    // Counter and registered outputs; duty_i/en_i are the parent's next-state
    // values so heater_on lines up with the cycle that duty takes effect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            armed_q        <= 1'b0;
            cnt_q          <= {PB{1'b0}};
            period_start_q <= 1'b0;
            heater_on_q    <= 1'b0;
        end else begin
            armed_q        <= 1'b1;
            cnt_q          <= cnt_d;
            period_start_q <= !armed_q || boundary_o;
            heater_on_q    <= en_i && (cnt_d < duty_i);
        end
    end

    assign period_start_o = period_start_q;
    assign heater_on_o    = heater_on_q;

endmodule

// File: rtl/heater_pwm_driver.sv
// Heater PWM driver: captures PID commands, applies them only at period
// boundaries, and trips a watchdog fault when commands stop arriving.
module heater_pwm_driver
    import heater_pkg::*;
#(
    parameter int unsigned WIDTH   = RESP_WIDTH,
    parameter int unsigned FRAC    = RESP_FRAC,
    parameter int unsigned PB      = 7,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] response,
    input  logic             computed,
    output logic             heater_on,
    output logic [PB-1:0]    duty,
    output logic             period_start,
    output logic             applied,
    output logic             fault
);

    localparam int unsigned     WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT - 1);

    drv_state_t        state_q, state_d;
    logic [PB-1:0]     duty_q, duty_d;
    logic [PB-1:0]     pending_q, pending_d;
    logic              pend_v_q, pend_v_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              fault_q, fault_d;
    logic              applied_q, applied_d;

    logic signed [31:0] resp_ext_s;
    logic [PB-1:0]      sat_s;
    logic               boundary_s;
    logic               run_d;

    assign resp_ext_s = {{(32-WIDTH){response[WIDTH-1]}}, response};
    assign sat_s      = PB'(sat_duty(resp_ext_s, FRAC, PB));
    assign run_d      = (state_d == RUN);

    pwm_counter #(
        .PB(PB)
    ) u_pwm_counter (
        .clk_i          (CLK),
        .rst_i          (RST),
        .duty_i         (duty_d),
        .en_i           (run_d),
        .boundary_o     (boundary_s),
        .period_start_o (period_start),
        .heater_on_o    (heater_on)
    );

    // Capture, boundary load (with same-edge bypass), watchdog and FSM.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        wd_d      = wd_q;
        fault_d   = fault_q;
        applied_d = 1'b0;

        if (computed) begin
            pending_d = sat_s;
            pend_v_d  = 1'b1;
            wd_d      = {WD_W{1'b0}};
        end else begin
            pending_d = pending_q;
        end

        if (boundary_s) begin
            if (!computed && (wd_q != WD_MAX)) begin
                wd_d = wd_q + {{(WD_W-1){1'b0}}, 1'b1};
            end else begin
                wd_d = wd_d;
            end

            if (computed || pend_v_q) begin
                duty_d    = computed ? sat_s : pending_q;
                pend_v_d  = 1'b0;
                applied_d = 1'b1;
                fault_d   = 1'b0;
                state_d   = RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        if (wd_q >= WD_TRIP) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                            duty_d  = {PB{1'b0}};
                        end else begin
                            state_d = RUN;
                        end
                    end
                    IDLE:    state_d = IDLE;
                    FAULT:   state_d = FAULT;
                    default: begin
                        state_d = IDLE;
                        duty_d  = {PB{1'b0}};
                        fault_d = 1'b0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and command registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            duty_q    <= {PB{1'b0}};
            pending_q <= {PB{1'b0}};
            pend_v_q  <= 1'b0;
            wd_q      <= {WD_W{1'b0}};
            fault_q   <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            wd_q      <= wd_d;
            fault_q   <= fault_d;
            applied_q <= applied_d;
        end
    end

    assign duty    = duty_q;
    assign fault   = fault_q;
    assign applied = applied_q;

endmodule
